// File: rtl/pipe_gap_gen_pkg.sv
// Shared definitions for the pipe gap generator and other randomised game blocks.
package pipe_gap_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          PIPE_Y_W  = 10;
  localparam int          SCREEN_H  = 480;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_gap_gen_if.sv
// Handshake between game controller / obstacle logic and the pipe gap generator.
interface pipe_gap_gen_if #(
  parameter int NUM_PIPES = 4,
  parameter int Y_W       = pipe_gap_gen_pkg::PIPE_Y_W,
  parameter int LVL_W     = 2
);
  import pipe_gap_gen_pkg::*;

  localparam int IW = (NUM_PIPES > 1) ? clog2(NUM_PIPES) : 1;

  logic                     start;
  logic [LVL_W-1:0]         level;
  logic [NUM_PIPES-1:0]     respawn;
  logic [NUM_PIPES*Y_W-1:0] y_top;
  logic [NUM_PIPES*Y_W-1:0] y_bot;
  logic                     ready;
  logic                     upd_valid;
  logic [IW-1:0]            upd_idx;

  modport master (
    output start, level, respawn,
    input  y_top, y_bot, ready, upd_valid, upd_idx
  );

  modport slave (
    input  start, level, respawn,
    output y_top, y_bot, ready, upd_valid, upd_idx
  );

endinterface

// File: rtl/pipe_gap_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift); a zero seed is promoted to 1.
module lfsr16
  import pipe_gap_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  localparam logic [15:0] INIT_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT_VAL;
    else     state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
  end

endmodule

// File: rtl/pipe_gap_gen.sv
// Loads random top/bottom gap edges for NUM_PIPES pipes on game start and on
// per-pipe respawn requests, lowest index first.
module pipe_gap_gen
  import pipe_gap_gen_pkg::*;
#(
  parameter int          NUM_PIPES = 4,
  parameter int          Y_W       = PIPE_Y_W,
  parameter int          Y_MIN     = 40,
  parameter int          Y_MAX     = 340,
  parameter int          GAP       = 100,
  parameter int          GAP_STEP  = 20,
  parameter int          GAP_MIN   = 50,
  parameter int          LVL_W     = 2,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input logic           clk,
  input logic           rst,
  pipe_gap_gen_if.slave bus
);

  localparam int RANGE   = Y_MAX - Y_MIN;
  localparam int RW      = (clog2(RANGE + 1) > 0) ? clog2(RANGE + 1) : 1;
  localparam int IW      = (NUM_PIPES > 1) ? clog2(NUM_PIPES) : 1;
  localparam int GAP_TOP = (GAP > GAP_MIN) ? GAP : GAP_MIN;

  if (Y_MAX + GAP_TOP >= (1 << Y_W)) begin : g_chk_width
    $error("pipe_gap_gen: Y_MAX + GAP does not fit in Y_W bits");
  end
  if (Y_MIN > Y_MAX) begin : g_chk_order
    $error("pipe_gap_gen: Y_MIN must not exceed Y_MAX");
  end
  if (RW > 16) begin : g_chk_lfsr
    $error("pipe_gap_gen: height range wider than the LFSR");
  end

  // Fold the raw LFSR slice into [0, RANGE]; RW is chosen so one subtraction suffices.
  function automatic logic [Y_W-1:0] map_top(input logic [15:0] l);
    logic signed [31:0] c;
    c = '0;
    c[RW-1:0] = l[RW-1:0];
    if (c > RANGE) c = c - (RANGE + 1);
    return Y_W'(Y_MIN + c);
  endfunction

  function automatic logic [Y_W-1:0] gap_for(input logic [LVL_W-1:0] lvl);
    logic signed [31:0] lv;
    logic signed [31:0] g;
    lv = 32'(lvl);
    g  = GAP - lv * GAP_STEP;
    if (g < GAP_MIN) g = GAP_MIN;
    return Y_W'(g);
  endfunction

  logic [15:0]              lfsr;
  state_t                   state, state_nx;
  logic [IW-1:0]            k, k_nx;
  logic [NUM_PIPES-1:0]     pending, pending_nx, req;
  logic                     load, sel_found;
  logic [IW-1:0]            load_idx, sel;
  logic [Y_W-1:0]           top_p0, bot_p0;
  logic [NUM_PIPES*Y_W-1:0] y_top, y_bot;
  logic                     ready, upd_valid;
  logic [IW-1:0]            upd_idx;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  assign top_p0 = map_top(lfsr);
  assign bot_p0 = top_p0 + gap_for(bus.level);

  always_comb begin
    req       = pending | bus.respawn;
    sel_found = 1'b0;
    sel       = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (req[i] && !sel_found) begin
        sel_found = 1'b1;
        sel       = IW'(i);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    k_nx       = k;
    pending_nx = pending;
    load       = 1'b0;
    load_idx   = k;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx   = INIT;
          k_nx       = '0;
          pending_nx = '0;
        end
      end
      INIT: begin
        load = 1'b1;
        k_nx = k + IW'(1);
        if (k == IW'(NUM_PIPES - 1)) state_nx = RUN;
      end
      RUN: begin
        pending_nx = req;
        if (sel_found) begin
          load            = 1'b1;
          load_idx        = sel;
          pending_nx[sel] = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A restart wins over any load that would otherwise happen this cycle.
    if (bus.start && state != IDLE) begin
      state_nx   = INIT;
      k_nx       = '0;
      pending_nx = '0;
      load       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      pending   <= '0;
      ready     <= 1'b0;
      upd_valid <= 1'b0;
      upd_idx   <= '0;
      y_top     <= '0;
      y_bot     <= '0;
    end else begin
      state     <= state_nx;
      k         <= k_nx;
      pending   <= pending_nx;
      ready     <= (state_nx == RUN);
      upd_valid <= load;
      if (load) begin
        upd_idx                           <= load_idx;
        y_top[int'(load_idx)*Y_W +: Y_W] <= top_p0;
        y_bot[int'(load_idx)*Y_W +: Y_W] <= bot_p0;
      end
    end
  end

  assign bus.y_top     = y_top;
  assign bus.y_bot     = y_bot;
  assign bus.ready     = ready;
  assign bus.upd_valid = upd_valid;
  assign bus.upd_idx   = upd_idx;

endmodule
